wrr_arbiter: RTL and testbench
==============================

# wrr_arbiter

Parametrised weighted round-robin arbiter with per-requester runtime weights, a downstream accept handshake and a lock for multi-beat transfers. It is the successor to the team's fixed single-weight round-robin arbiter. It sits in front of shared CAM search/write ports and crossbar outputs wherever N sources compete for one resource. Requester i may take weight[i]+1 consecutive accepted grants before priority rotates past it.

## Interface
- N, 4, number of requesters (≥2)
- CW, 2, width of each per-requester weight field
- IW, derived clogb(N) (min 1), width of grant index
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N  request vector, bit i = requester i
- weight  in  N*CW  weight[i] = weight[i*CW +: CW]; grants per turn = weight[i]+1
- lock  in  1  when high on an accepted beat, the winner keeps ownership and consumes no credit
- gnt  out  N  one-hot grant, all-zero when req == 0
- gnt_idx  out  IW  binary index of gnt bit, 0 when no grant
- gnt_valid  out  1  |req
- gnt_ready  in  1  downstream accepts current grant this cycle

## Operation
- State: ptr (N-bit one-hot priority pointer, reset 'b1); cnt (CW-bit credit counter, reset 0).
- Pick: gnt selects the first set req bit at or above ptr, wrapping from N-1 to 0. The pick is combinational and is a pure function of req, ptr and cnt.
- Accept condition: acc = gnt_valid & gnt_ready. No accept means ptr and cnt hold.
- eff = (gnt == ptr) ? cnt : 0. A winner that is not the current owner starts with a fresh count.
- On acc with lock = 1 and req[winner] = 1:
  - ptr <= gnt.
  - cnt <= eff.
  - No credit is consumed.
- On acc with lock = 0:
  - If eff ≥ weight[winner]: ptr <= gnt rotated left by 1 (bit N-1 wraps to bit 0), and cnt <= 0.
  - Otherwise: ptr <= gnt, and cnt <= eff+1.
- Comparison uses ≥. If weight is lowered below the current cnt mid-turn, the next accept advances the pointer. A weight change takes effect on the next accept.
- Owner drops req: the next winner is found from ptr onward. Its eff is 0, so lock and credit history do not carry over.
- req == 0: gnt = 0, gnt_idx = 0, gnt_valid = 0. State holds, and gnt_ready is ignored.
- A single requester with weight W and continuous accepts is granted every cycle. ptr rotates away and back through the pick, and cnt cycles 0..W.
- gnt is stable while req, ptr and cnt are unchanged. A request withdrawn before acceptance is legal and changes gnt in the same cycle.

## Timing
- Grant latency: 0 cycles, req to gnt/gnt_idx/gnt_valid combinational.
- State update: on the clk edge where acc = 1. The new priority is visible in the following cycle.
- Reset: ptr = 'b1 and cnt = 0 immediately, asynchronously.
  - During and after reset, outputs follow the pick with ptr = 1: gnt = lowest set req bit, gnt_idx = its index, gnt_valid = |req.
  - Reset mid-lock or mid-turn discards ownership and credit.
- gnt_ready has no combinational path into gnt (no loop).

## Structure
- Shared package arb_pkg: clogb function, IW derivation, and the weight-slice indexing constant.
- Sub-module rr_pick: combinational. Performs the double-width masked first-one search, {req,req} & ~({req,req} - ptr) folded to N bits, plus one-hot-to-binary encode. Other arbiters reuse it.
- The top holds ptr/cnt registers, the eff/advance logic and the lock gating.

## Test plan
- N=4, all weights 0, req=4'b1111, gnt_ready=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; gnt_idx 0,1,2,3,0.
- weight={0,0,0,2} (req0 weight 2), req=1111, ready=1 -> gnt0 for 3 cycles, then gnt1, gnt2, gnt3, gnt0 ×3.
- req=0101, ready=0 for 5 cycles -> gnt=0001 held, ptr/cnt unchanged. Then ready=1 -> next cycle gnt=0100.
- lock=1 with req0 winning and ready=1 for 6 cycles, weight 0 -> gnt0 every cycle. lock=0 -> the following cycle gnt moves to the next set req bit.
- Mid-turn (cnt=1, weight[0]=3), drop weight[0] to 0 -> the next accept advances ptr. Separately, assert rst mid-turn with req=1100 -> gnt=0100, gnt_idx=2 immediately.
- req=0 -> gnt=0, gnt_idx=0, gnt_valid=0 with ready toggling. Then req=1000 -> gnt=1000, gnt_idx=3 same cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter helpers: index-width derivation and weight-field slicing.
package arb_pkg;

  function automatic int clogb(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Low bit of requester idx's field inside a packed weight vector.
  function automatic int wslice_lo(input int idx, input int cw);
    return idx * cw;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or above the one-hot ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clogb(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dreq_s;
  logic [2*N-1:0] dgnt_s;

  // The borrow from subtracting ptr clears everything except the first set bit at or above ptr.
  assign dreq_s = {req_i, req_i};
  assign dgnt_s = dreq_s & ~(dreq_s - {{N{1'b0}}, ptr_i});
  assign gnt_o  = dgnt_s[N-1:0] | dgnt_s[2*N-1:N];

  // One-hot to binary encode of the grant.
  always_comb begin
    idx_o = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_o = idx_o | ({IW{gnt_o[i]}} & IW'(i));
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: owner may take weight+1 accepted grants, lock holds ownership.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 2,
  parameter int IW = clogb(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic [N*CW-1:0] weight_i,
  input  logic            lock_i,
  input  logic            gnt_ready_i,
  output logic [N-1:0]    gnt_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            gnt_valid_o
);

  logic [N-1:0]  ptr_q;
  logic [N-1:0]  ptr_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [N-1:0]  gnt_s;
  logic [IW-1:0] idx_s;
  logic [CW-1:0] eff_s;
  logic [CW-1:0] wsel_s;
  logic          acc_s;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (idx_s)
  );

  assign gnt_o       = gnt_s;
  assign gnt_idx_o   = idx_s;
  assign gnt_valid_o = |req_i;
  assign acc_s       = gnt_valid_o & gnt_ready_i;

  // A winner that is not the current owner starts its turn with no credit used.
  assign eff_s  = (gnt_s == ptr_q) ? cnt_q : {CW{1'b0}};
  assign wsel_s = weight_i[wslice_lo(int'(idx_s), CW) +: CW];

  // Next priority pointer and credit count on an accepted beat.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (acc_s) begin
      if (lock_i) begin
        ptr_d = gnt_s;
        cnt_d = eff_s;
      end else if (eff_s >= wsel_s) begin
        ptr_d = {gnt_s[N-2:0], gnt_s[N-1]};
        cnt_d = {CW{1'b0}};
      end else begin
        ptr_d = gnt_s;
        cnt_d = eff_s + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Priority pointer and credit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= {{(N-1){1'b0}}, 1'b1};
      cnt_q <= {CW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed plus randomized bench for wrr_arbiter against a turn-based reference model.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*CW-1:0] weight;
  logic            lock;
  logic            gnt_ready;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_valid;

  int vectors     = 0;
  int miscompares = 0;
  int m_owner     = 0;
  int m_used      = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .CW(CW), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .weight_i    (weight),
    .lock_i      (lock),
    .gnt_ready_i (gnt_ready),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  function automatic int m_pick(input logic [N-1:0] r, input int owner);
    for (int k = 0; k < N; k++) begin
      if (r[(owner + k) % N]) return (owner + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, then advance the model.
  task automatic step(input logic rs, input logic [N-1:0] r, input logic [N*CW-1:0] w,
                      input logic l, input logic rdy);
    int win;
    int eff;
    int wt;
    @(negedge clk);
    rst = rs; req = r; weight = w; lock = l; gnt_ready = rdy;
    if (rs) begin
      m_owner = 0;
      m_used  = 0;
    end
    #1;
    win = m_pick(r, m_owner);
    check("gnt", 32'(gnt), (win < 0) ? 32'd0 : (32'd1 << win));
    check("gnt_idx", 32'(gnt_idx), (win < 0) ? 32'd0 : 32'(win));
    check("gnt_valid", 32'(gnt_valid), 32'(r != 4'b0000));
    if (!rs && win >= 0 && rdy) begin
      eff = (win == m_owner) ? m_used : 0;
      wt  = int'((w >> (win * CW)) & 8'h03);
      if (l) begin
        m_owner = win;
        m_used  = eff;
      end else if (eff >= wt) begin
        m_owner = (win + 1) % N;
        m_used  = 0;
      end else begin
        m_owner = win;
        m_used  = eff + 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; weight = 8'h00; lock = 1'b0; gnt_ready = 1'b0;

    // Reset state with requests present: lowest set bit wins.
    step(1'b1, 4'b0110, 8'h00, 1'b0, 1'b1);

    // Equal weights: plain rotation.
    step(1'b1, 4'b1111, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b1111, 8'h00, 1'b0, 1'b1);
      check("rr_seq", 32'(gnt), 32'd1 << (k % 4));
    end

    // Requester 0 with weight 2 takes three grants per turn.
    step(1'b1, 4'b1111, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'b1111, 8'h02, 1'b0, 1'b1);
      check("wrr_seq", 32'(gnt_idx), (k % 6 < 3) ? 32'd0 : 32'(k % 6 - 2));
    end

    // No ready: grant and state hold; one accept moves on.
    step(1'b1, 4'b0101, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0101, 8'h00, 1'b0, 1'b0);
      check("hold_gnt", 32'(gnt), 32'h1);
    end
    step(1'b0, 4'b0101, 8'h00, 1'b0, 1'b1);
    step(1'b0, 4'b0101, 8'h00, 1'b0, 1'b1);
    check("after_hold", 32'(gnt), 32'h4);

    // Lock keeps requester 0, release rotates.
    step(1'b1, 4'b1111, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b1111, 8'h00, 1'b1, 1'b1);
      check("lock_gnt", 32'(gnt), 32'h1);
    end
    step(1'b0, 4'b1111, 8'h00, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 8'h00, 1'b0, 1'b1);
    check("unlock_gnt", 32'(gnt), 32'h2);

    // Lowering weight below used credit advances at the next accept.
    step(1'b1, 4'b1111, 8'h00, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 8'h03, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 8'h00, 1'b0, 1'b1);
    check("wdrop_still0", 32'(gnt), 32'h1);
    step(1'b0, 4'b1111, 8'h00, 1'b0, 1'b1);
    check("wdrop_adv", 32'(gnt), 32'h2);

    // Reset mid-turn discards ownership immediately.
    step(1'b0, 4'b1111, 8'h0C, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 8'h0C, 1'b0, 1'b1);
    step(1'b1, 4'b1100, 8'h0C, 1'b0, 1'b1);
    check("rst_mid_gnt", 32'(gnt), 32'h4);
    check("rst_mid_idx", 32'(gnt_idx), 32'd2);

    // No requests with ready toggling, then a lone top requester.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b0000, 8'h00, 1'b0, 1'(k & 1));
    end
    step(1'b0, 4'b1000, 8'h00, 1'b0, 1'b1);
    check("lone_gnt", 32'(gnt), 32'h8);
    check("lone_idx", 32'(gnt_idx), 32'd3);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 49) == 0), 4'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
